// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle for one side of a pipeline stage boundary.
// The master drives valid/data, the slave drives ready.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush-to-bubble
// and an optional two-entry skid buffer so that up.ready can come straight from a flop.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_EMPTY | no entry held, out_valid=0, out_data=BUBBLE_VAL
// ST_FULL  | one entry in r_main, presented downstream
// ST_SKIDF | r_main presented, second entry parked in r_skid (SKID=1 only)
module pipe_stage_reg #(
  parameter int                DATA_W     = 64,
  parameter int                SKID       = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_stage_reg_if.slave       up,
  pipe_stage_reg_if.master      dn,
  input  logic                  flush,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKIDF = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              r_in_ready;
  logic [1:0]        r_occ;
  logic [1:0]        w_occ_nxt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = up.valid & w_in_ready;
  assign w_out_fire = w_out_valid & dn.ready;

  assign up.ready   = w_in_ready;
  assign dn.valid   = w_out_valid;
  assign dn.data    = r_main;
  assign occupancy  = r_occ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_main     <= BUBBLE_VAL;
      r_skid     <= BUBBLE_VAL;
      r_in_ready <= 1'b1;
      r_occ      <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != ST_SKIDF);
      r_occ      <= w_occ_nxt;
    end
  end

  // Flush wins over everything; an entry leaving on the same edge is already delivered.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE_VAL;
      w_skid_nxt  = BUBBLE_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = up.data;
          end
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = up.data;
          end else if (w_in_fire && (SKID != 0)) begin
            w_state_nxt = ST_SKIDF;
            w_skid_nxt  = up.data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE_VAL;
          end
        end
        ST_SKIDF: begin
          if (w_out_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE_VAL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE_VAL;
          w_skid_nxt  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_comb begin
    w_out_valid = (r_state != ST_EMPTY);
    w_in_ready  = (SKID != 0) ? r_in_ready : (~w_out_valid | dn.ready);
    case (w_state_nxt)
      ST_FULL:  w_occ_nxt = 2'd1;
      ST_SKIDF: w_occ_nxt = 2'd2;
      default:  w_occ_nxt = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=0 and a SKID=1 instance side by side, each
// shadowed by a queue model of the entries it should be holding.
module tb_pipe_stage_reg;

  localparam int         DW  = 8;
  localparam logic [7:0] BUB = 8'h5A;

  logic clk;
  logic rst_n;

  logic       in_valid  [2];
  logic [7:0] in_data   [2];
  logic       out_ready [2];
  logic       flush     [2];
  logic       ov        [2];
  logic [7:0] od        [2];
  logic       ir        [2];
  logic [1:0] occ       [2];

  int vectors;
  int miscompares;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  pipe_stage_reg_if #(.DATA_W(DW)) u_if0 ();
  pipe_stage_reg_if #(.DATA_W(DW)) d_if0 ();
  pipe_stage_reg_if #(.DATA_W(DW)) u_if1 ();
  pipe_stage_reg_if #(.DATA_W(DW)) d_if1 ();

  assign u_if0.valid = in_valid[0];
  assign u_if0.data  = in_data[0];
  assign d_if0.ready = out_ready[0];
  assign u_if1.valid = in_valid[1];
  assign u_if1.data  = in_data[1];
  assign d_if1.ready = out_ready[1];
  assign ov[0] = d_if0.valid;
  assign od[0] = d_if0.data;
  assign ir[0] = u_if0.ready;
  assign ov[1] = d_if1.valid;
  assign od[1] = d_if1.data;
  assign ir[1] = u_if1.ready;

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .BUBBLE_VAL(BUB)) u_dut0 (
    .clk       (clk),
    .reset     (rst_n),
    .up        (u_if0),
    .dn        (d_if0),
    .flush     (flush[0]),
    .occupancy (occ[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .BUBBLE_VAL(BUB)) u_dut1 (
    .clk       (clk),
    .reset     (rst_n),
    .up        (u_if1),
    .dn        (d_if1),
    .flush     (flush[1]),
    .occupancy (occ[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage 1 has skid room for two entries; stage 0 only accepts when it can drain.
  function automatic bit exp_rdy(input int d, input int sz);
    if (d == 1) return sz < 2;
    return (sz == 0) || (out_ready[0] == 1'b1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin : model_upd
      bit fi0, fo0, fi1, fo1;
      fi0 = in_valid[0] && exp_rdy(0, q0.size());
      fo0 = (q0.size() != 0) && out_ready[0];
      fi1 = in_valid[1] && exp_rdy(1, q1.size());
      fo1 = (q1.size() != 0) && out_ready[1];
      if (flush[0]) q0.delete();
      else begin
        if (fo0) void'(q0.pop_front());
        if (fi0) q0.push_back(in_data[0]);
      end
      if (flush[1]) q1.delete();
      else begin
        if (fo1) void'(q1.pop_front());
        if (fi1) q1.push_back(in_data[1]);
      end
    end
  end

  task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic check_model(input int d);
    int         sz;
    logic [7:0] head;
    sz   = (d == 0) ? q0.size() : q1.size();
    head = BUB;
    if (sz != 0) head = (d == 0) ? q0[0] : q1[0];
    chk("m_out_valid", d, {7'd0, ov[d]}, {7'd0, sz != 0});
    chk("m_out_data",  d, od[d], head);
    chk("m_occupancy", d, {6'd0, occ[d]}, sz[7:0]);
    chk("m_in_ready",  d, {7'd0, ir[d]}, {7'd0, exp_rdy(d, sz)});
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'h00;
      out_ready[d] = 1'b0;
      flush[d]     = 1'b0;
    end
  endtask

  // Inputs are already set; check mid-cycle, then move just past the next edge.
  task automatic step();
    @(negedge clk);
    check_model(0);
    check_model(1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       ov;
    logic [7:0] od;
    logic [1:0] occ;
    logic       ir;
  } vec_t;

  vec_t tbl[18];

  initial begin
    vectors     = 0;
    miscompares = 0;

    // inputs for the cycle | expected SKID=1 outputs seen before that cycle's edge
    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[6]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[11] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[12] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB1, 2'd1, 1'b1};
    tbl[13] = '{1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 8'hB1, 2'd2, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[15] = '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, BUB,   2'd0, 1'b1};
    tbl[16] = '{1'b1, 8'hC2, 1'b1, 1'b1, 1'b1, 8'hC1, 2'd1, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, BUB,   2'd0, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = tbl[i].iv;
        in_data[d]   = tbl[i].d;
        out_ready[d] = tbl[i].ordy;
        flush[d]     = tbl[i].fl;
      end
      @(negedge clk);
      check_model(0);
      check_model(1);
      chk("t_out_valid", 1, {7'd0, ov[1]}, {7'd0, tbl[i].ov});
      chk("t_out_data",  1, od[1], tbl[i].od);
      chk("t_occupancy", 1, {6'd0, occ[1]}, {6'd0, tbl[i].occ});
      chk("t_in_ready",  1, {7'd0, ir[1]}, {7'd0, tbl[i].ir});
      @(posedge clk);
      #1;
    end

    // SKID=0: ready follows out_ready within the cycle, and a joint fire swaps with no bubble
    idle_inputs();
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hD1;
    step();
    in_data[0] = 8'hD2;
    @(negedge clk);
    check_model(0);
    chk("s0_stall_rdy", 0, {7'd0, ir[0]}, 8'd0);
    chk("s0_stall_data", 0, od[0], 8'hD1);
    out_ready[0] = 1'b1;
    #1;
    chk("s0_comb_rdy", 0, {7'd0, ir[0]}, 8'd1);
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    @(negedge clk);
    check_model(0);
    chk("s0_swap_valid", 0, {7'd0, ov[0]}, 8'd1);
    chk("s0_swap_data", 0, od[0], 8'hD2);
    @(posedge clk);
    #1;

    // Asynchronous reset while holding 0xC5
    idle_inputs();
    in_valid[1] = 1'b1;
    in_data[1]  = 8'hC5;
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    check_model(0);
    check_model(1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("r_out_valid", d, {7'd0, ov[d]}, 8'd0);
      chk("r_out_data",  d, od[d], BUB);
      chk("r_occupancy", d, {6'd0, occ[d]}, 8'd0);
      chk("r_in_ready",  d, {7'd0, ir[d]}, 8'd1);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    in_valid[1]  = 1'b1;
    in_data[1]   = 8'h77;
    out_ready[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    check_model(1);
    chk("r_after_data", 1, od[1], 8'h77);
    @(posedge clk);
    #1;

    // Random stall/flush soak on both instances
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = ($urandom_range(3) != 0);
        in_data[d]   = 8'($urandom);
        out_ready[d] = ($urandom_range(2) != 0);
        flush[d]     = ($urandom_range(31) == 0);
      end
      step();
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. It replaces the fixed per-stage registers (IF/ID, ID/EX, ...) that carry PC+4 and decoded control fields.
- Adds a valid/ready handshake, back-pressure, flush-to-bubble and an optional 2-entry skid buffer so that in_ready is a registered output.
- Sits between any two pipeline stages; the payload is the concatenated stage bundle.

Parameters:
- DATA_W, 64, width of the payload bundle in bits (>=1).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- BUBBLE_VAL, {DATA_W{1'b0}}, payload value presented whenever the stage is empty (control fields decode to a NOP).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds valid payload.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous kill of all held entries (branch/exception redirect).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload to the next stage.
- occupancy  out  2  number of held entries (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (reset low, asynchronous, effective immediately):
  - out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1, skid entry cleared, state EMPTY.
  - Reset mid-transfer discards all held data.
  - Release is synchronous-safe: the first active edge after reset goes high behaves as EMPTY.
- Invariant: out_valid=0 implies out_data==BUBBLE_VAL.
- Invariant: while out_valid=1 & out_ready=0, out_data and out_valid are held stable.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput: 1 transfer per cycle when out_ready is continuously high.
- States for SKID=1 (main = output register, skid = second entry):
  - EMPTY (occ 0): in_fire -> FULL, main<=in_data; else stay.
  - FULL (occ 1):
    - in_fire & out_fire -> FULL, main<=in_data.
    - in_fire & !out_fire -> SKIDF, skid<=in_data.
    - !in_fire & out_fire -> EMPTY, main<=BUBBLE_VAL.
    - else hold.
  - SKIDF (occ 2): in_ready=0.
    - out_fire -> FULL, main<=skid (FIFO order preserved).
    - else hold.
  - in_ready is a register: 1 in EMPTY and FULL, 0 in SKIDF. It does not depend combinationally on out_ready.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - States are EMPTY and FULL only.
  - Transitions are as above, except that in FULL the case in_fire & !out_fire cannot occur.
- flush: takes priority over every other event in the same cycle.
  - Next state is EMPTY: main<=BUBBLE_VAL, skid cleared, occupancy=0, in_ready=1.
  - A payload that fires on the input in the flush cycle is discarded.
  - A payload that fires on the output in the flush cycle counts as delivered; downstream owns it.
- occupancy is registered and always equals the number of valid entries (0/1/2).
- No payload is duplicated, dropped (other than by flush or reset), or reordered.

Test Plan:
- Streaming: reset, then send 0x11,0x22,0x33 back-to-back with out_ready=1 -> out_valid high from cycle 1, out_data 0x11,0x22,0x33 on consecutive cycles, occupancy=1 throughout.
- Back-pressure, SKID=1:
  - Send 0xA1,0xA2 with out_ready=0 -> occupancy 1 then 2, in_ready=0 after the second accept, out_data held at 0xA1.
  - Raise out_ready -> 0xA1 then 0xA2 delivered, then out_valid=0 and out_data=BUBBLE_VAL.
- Flush with full skid: occupancy=2, assert flush together with in_valid=1 (0xB0) -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL, in_ready=1; 0xB0 never appears.
- Asynchronous reset: pull reset low mid-cycle while FULL with 0xC5 -> outputs immediately at reset values before the next clk edge; after release, the stage accepts a new payload normally.
- SKID=0: with out_valid=1 and out_ready=0 -> in_ready=0 in the same cycle. Toggle out_ready=1 -> in_ready=1 in the same cycle, and a simultaneous in/out fire replaces the payload with no bubble.
- Random stall/flush soak (10k cycles, both SKID values): scoreboard confirms in-order, lossless delivery outside flushes, and the out_valid=0 => out_data==BUBBLE_VAL invariant.
